// File: rtl/spi_arb_pkg.sv
// Shared types for the two-master SPI bus arbiter: FSM states, owner codes and
// the bundle of pad-side pins that the pin mux selects and registers.
package spi_arb_pkg;

    // Width of the select field carried in spi_pins_t; the arbiter's N_SS must match.
    localparam int SS_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_PS = 2'd1,
        OWN_PL = 2'd2,
        GUARD  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_PS_ID = 2'd1,
        OWN_PL_ID = 2'd2
    } owner_t;

    typedef struct packed {
        logic            sck;
        logic            sck_t;
        logic            mosi;
        logic            mosi_t;
        logic [SS_W-1:0] ss_n;
    } spi_pins_t;

    function automatic spi_pins_t parked_pins(input logic cpol);
        return '{sck: cpol, sck_t: 1'b0, mosi: 1'b0, mosi_t: 1'b1, ss_n: '1};
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of requester, pad and status signals around the SPI bus arbiter.
// master = surrounding system (PS, PL engine, pads); slave = the arbiter.
interface spi_bus_arbiter_if #(
    parameter int N_SS = 3
);
    logic            ps_req;
    logic            ps_gnt;
    logic            ps_sck_o;
    logic            ps_sck_t;
    logic            ps_mosi_o;
    logic            ps_mosi_t;
    logic [N_SS-1:0] ps_ss_n;
    logic            ps_miso_i;
    logic            ps_sck_i;
    logic            ps_ss_i;

    logic            pl_req;
    logic            pl_gnt;
    logic            pl_sck;
    logic            pl_mosi;
    logic [N_SS-1:0] pl_ss_n;
    logic            pl_miso;

    logic            spi_sck_o;
    logic            spi_sck_t;
    logic            spi_mosi_o;
    logic            spi_mosi_t;
    logic [N_SS-1:0] spi_ss_n_o;
    logic            spi_miso_i;

    logic            revoke_err;
    logic [1:0]      owner;

    modport master (
        output ps_req, ps_sck_o, ps_sck_t, ps_mosi_o, ps_mosi_t, ps_ss_n,
        output pl_req, pl_sck, pl_mosi, pl_ss_n,
        output spi_miso_i,
        input  ps_gnt, ps_miso_i, ps_sck_i, ps_ss_i,
        input  pl_gnt, pl_miso,
        input  spi_sck_o, spi_sck_t, spi_mosi_o, spi_mosi_t, spi_ss_n_o,
        input  revoke_err, owner
    );

    modport slave (
        input  ps_req, ps_sck_o, ps_sck_t, ps_mosi_o, ps_mosi_t, ps_ss_n,
        input  pl_req, pl_sck, pl_mosi, pl_ss_n,
        input  spi_miso_i,
        output ps_gnt, ps_miso_i, ps_sck_i, ps_ss_i,
        output pl_gnt, pl_miso,
        output spi_sck_o, spi_sck_t, spi_mosi_o, spi_mosi_t, spi_ss_n_o,
        output revoke_err, owner
    );

endinterface

// File: rtl/spi_pin_mux.sv
// Registered pad mux: picks the PS or PL pin bundle, or forces the parked
// idle levels, one cycle ahead of the pads so the pads never glitch.
module spi_pin_mux
    import spi_arb_pkg::*;
#(
    parameter logic CPOL = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  spi_pins_t ps_pins_i,
    input  spi_pins_t pl_pins_i,
    input  logic      sel_pl_i,
    input  logic      park_i,
    output spi_pins_t pad_o
);

    spi_pins_t pad_d;
    spi_pins_t pad_q;

    // NOTE: assign the default first so every path writes pad_d and no latch is inferred.
    always_comb begin
        pad_d = parked_pins(CPOL);
        if (!park_i) begin
            pad_d = sel_pl_i ? pl_pins_i : ps_pins_i;
        end
    end

    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_q <= parked_pins(CPOL);
        end else begin
            pad_q <= pad_d;
        end
    end

    assign pad_o = pad_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Hands one SPI bus to either the PS EMIO controller or the PL engine by
// request/grant, switching only when the owner's selects are idle, with a guard gap.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int          N_SS         = SS_W,
    parameter logic        CPOL         = 1'b0,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned HOLD_MAX     = 0
) (
    input  logic             axi_aclk,
    input  logic             reset,
    spi_bus_arbiter_if.slave bus
);

    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_MAX - 1);
    localparam logic        HOLD_EN    = (HOLD_MAX != 0);

    arb_state_t  state_q, state_d;
    owner_t      last_owner_q, last_owner_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        revoke_err_q, revoke_err_d;
    logic        ps_lock_q, ps_lock_d;
    logic        pl_lock_q, pl_lock_d;

    logic        ps_ok, pl_ok;
    logic        own, own_req, own_ss_idle;
    logic        release_now, revoke_now;
    logic        park, sel_pl;
    owner_t      owner_c;
    spi_pins_t   ps_pins, pl_pins, pad;

    // A revoked requester stays locked out until its req has been seen low.
    assign ps_ok = bus.ps_req & ~ps_lock_q;
    assign pl_ok = bus.pl_req & ~pl_lock_q;

    assign own         = (state_q == OWN_PS) || (state_q == OWN_PL);
    assign own_req     = (state_q == OWN_PL) ? bus.pl_req : bus.ps_req;
    assign own_ss_idle = (state_q == OWN_PL) ? (&bus.pl_ss_n) : (&bus.ps_ss_n);
    assign release_now = own && !own_req && own_ss_idle;
    assign revoke_now  = own && HOLD_EN && (hold_cnt_q == HOLD_LAST) && !release_now;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        guard_cnt_d  = guard_cnt_q;
        hold_cnt_d   = '0;
        revoke_err_d = revoke_err_q;
        park         = 1'b1;
        sel_pl       = 1'b0;

        case (state_q)
            IDLE: begin
                if (ps_ok && (!pl_ok || last_owner_q == OWN_PL_ID)) begin
                    state_d = OWN_PS;
                end else if (pl_ok) begin
                    state_d = OWN_PL;
                end
            end
            OWN_PS, OWN_PL: begin
                sel_pl     = (state_q == OWN_PL);
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (release_now || revoke_now) begin
                    state_d      = GUARD;
                    guard_cnt_d  = '0;
                    last_owner_d = (state_q == OWN_PL) ? OWN_PL_ID : OWN_PS_ID;
                    revoke_err_d = revoke_err_q | revoke_now;
                end else begin
                    park = 1'b0;
                end
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ps_lock_d = ps_lock_q & bus.ps_req;
        pl_lock_d = pl_lock_q & bus.pl_req;
        if (revoke_now && state_q == OWN_PS) ps_lock_d = 1'b1;
        if (revoke_now && state_q == OWN_PL) pl_lock_d = 1'b1;
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_PL_ID;
            guard_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            revoke_err_q <= 1'b0;
            ps_lock_q    <= 1'b0;
            pl_lock_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            guard_cnt_q  <= guard_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            revoke_err_q <= revoke_err_d;
            ps_lock_q    <= ps_lock_d;
            pl_lock_q    <= pl_lock_d;
        end
    end

    always_comb begin
        owner_c = OWN_NONE;
        if (state_q == OWN_PS) owner_c = OWN_PS_ID;
        if (state_q == OWN_PL) owner_c = OWN_PL_ID;
    end

    assign ps_pins = '{sck: bus.ps_sck_o, sck_t: bus.ps_sck_t, mosi: bus.ps_mosi_o,
                       mosi_t: bus.ps_mosi_t, ss_n: bus.ps_ss_n};
    assign pl_pins = '{sck: bus.pl_sck, sck_t: 1'b0, mosi: bus.pl_mosi,
                       mosi_t: 1'b0, ss_n: bus.pl_ss_n};

    spi_pin_mux #(
        .CPOL (CPOL)
    ) u_pin_mux (
        .clk       (axi_aclk),
        .reset     (reset),
        .ps_pins_i (ps_pins),
        .pl_pins_i (pl_pins),
        .sel_pl_i  (sel_pl),
        .park_i    (park),
        .pad_o     (pad)
    );

    assign bus.spi_sck_o  = pad.sck;
    assign bus.spi_sck_t  = pad.sck_t;
    assign bus.spi_mosi_o = pad.mosi;
    assign bus.spi_mosi_t = pad.mosi_t;
    assign bus.spi_ss_n_o = pad.ss_n;

    assign bus.ps_gnt     = (state_q == OWN_PS);
    assign bus.pl_gnt     = (state_q == OWN_PL);
    assign bus.ps_miso_i  = (state_q == OWN_PS) & bus.spi_miso_i;
    assign bus.pl_miso    = (state_q == OWN_PL) & bus.spi_miso_i;
    assign bus.ps_sck_i   = CPOL;
    assign bus.ps_ss_i    = 1'b1;
    assign bus.revoke_err = revoke_err_q;
    assign bus.owner      = owner_c;

endmodule
